joypad_ports: RTL

Memory-mapped responder on the CPU bus for the two NES controller ports at $4016/$4017.
- The CPU is the bus initiator; this block decodes its address and rw, accepts the strobe write, and supplies the serial button bit on reads.
- Holds one 8-bit parallel-in/serial-out shift register per port, loaded from synchronised button inputs.
- Sits beside work RAM and the PPU register block in the CPU address decode fabric.

---
 rtl/joypad_pkg.sv | 33 +++
 rtl/joypad_shift_register.sv | 68 ++++++
 rtl/joypad_ports.sv | 110 +++++++++++
 3 files changed

// File: rtl/joypad_pkg.sv
// Shared constants for the NES controller port block: button bit positions,
// default bus addresses and the saturation limit of the per-port read counter.
package joypad_pkg;

  // Button bit positions inside an 8-bit controller report.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Default CPU addresses of the two controller ports.
  localparam logic [15:0] DEFAULT_ADDRESS_PORT1 = 16'h4016;
  localparam logic [15:0] DEFAULT_ADDRESS_PORT2 = 16'h4017;

  // The read counter stops once all eight report bits have been consumed.
  localparam logic [3:0] COUNT_SAT = 4'd8;

  // Saturating increment of the consumed-bit counter.
  function automatic logic [3:0] count_sat_inc(input logic [3:0] count);
    logic [3:0] result;
    if (count >= COUNT_SAT) begin
      result = COUNT_SAT;
    end else begin
      result = count + 4'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/joypad_shift_register.sv
// One controller port: button synchroniser chain, 8-bit parallel-in /
// serial-out shift register and saturating count of bits consumed.
// A reload (i_load) always wins over a shift in the same cycle.
module joypad_shift_register
  import joypad_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic [7:0] i_buttons,
  output logic [7:0] o_shift,
  output logic [3:0] o_count
);

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic [3:0] count_q;
  logic [3:0] count_d;

  // Bring the asynchronous button levels into the clock domain.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= 8'h00;
      end
    end else begin
      sync_q[0] <= i_buttons;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Next-state: reload from synced buttons, else shift in a 1 from the top.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (i_load) begin
      shift_d = sync_q[SYNC_STAGES-1];
      count_d = 4'd0;
    end else if (i_shift) begin
      shift_d = {1'b1, shift_q[7:1]};
      count_d = count_sat_inc(count_q);
    end else begin
      shift_d = shift_q;
      count_d = count_q;
    end
  end

  // Shift register and counter state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= 8'h00;
      count_q <= 4'd0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  assign o_shift = shift_q;
  assign o_count = count_q;

endmodule

// File: rtl/joypad_ports.sv
// CPU-bus responder for the two NES controller ports ($4016/$4017).
// A write to port 1 sets the strobe latch; reads return the serial button
// bit of the addressed port and advance that port's shift register.
// Optional macro JOYPAD_OPEN_BUS_EN: claimed reads drive o_data[7:5] with
// the upper address bits (open-bus emulation) instead of zero.
module joypad_ports
  import joypad_pkg::*;
#(
  parameter logic [15:0] ADDRESS_PORT1 = DEFAULT_ADDRESS_PORT1,
  parameter logic [15:0] ADDRESS_PORT2 = DEFAULT_ADDRESS_PORT2,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rw,
  input  logic [15:0] i_address,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        o_cs,
  input  logic [7:0]  i_buttons_1,
  input  logic [7:0]  i_buttons_2,
  output logic        o_strobe,
  output logic [7:0]  o_debug_shift_1,
  output logic [7:0]  o_debug_shift_2,
  output logic [3:0]  o_debug_count_1,
  output logic [3:0]  o_debug_count_2
);

  logic       rd1_s;
  logic       rd2_s;
  logic       wr1_s;
  logic       strobe_q;
  logic       strobe_d;
  logic [7:0] shift_1_s;
  logic [7:0] shift_2_s;
  logic [2:0] upper_s;
  logic       unused_data_s;

  // Only bit 0 of the strobe write is meaningful.
  assign unused_data_s = ^i_data[7:1];

  // Bus decode; writes to port 2 belong to the APU and are not claimed.
  always_comb begin
    rd1_s = i_rw & (i_address == ADDRESS_PORT1);
    rd2_s = i_rw & (i_address == ADDRESS_PORT2);
    wr1_s = ~i_rw & (i_address == ADDRESS_PORT1);
  end

`ifdef JOYPAD_OPEN_BUS_EN
  assign upper_s = i_address[15:13];
`else
  assign upper_s = 3'b000;
`endif

  // Read data is combinational so the CPU can latch it at the cycle's edge.
  always_comb begin
    o_data = 8'h00;
    o_cs   = rd1_s | rd2_s | wr1_s;
    if (rd1_s) begin
      o_data = {upper_s, 4'b0000, shift_1_s[0]};
    end else if (rd2_s) begin
      o_data = {upper_s, 4'b0000, shift_2_s[0]};
    end else begin
      o_data = 8'h00;
    end
  end

  // Strobe latch next-state.
  always_comb begin
    if (wr1_s) begin
      strobe_d = i_data[0];
    end else begin
      strobe_d = strobe_q;
    end
  end

  // Strobe latch register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign o_strobe        = strobe_q;
  assign o_debug_shift_1 = shift_1_s;
  assign o_debug_shift_2 = shift_2_s;

  joypad_shift_register #(.SYNC_STAGES(SYNC_STAGES)) u_port1 (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (strobe_q),
    .i_shift   (rd1_s),
    .i_buttons (i_buttons_1),
    .o_shift   (shift_1_s),
    .o_count   (o_debug_count_1)
  );

  joypad_shift_register #(.SYNC_STAGES(SYNC_STAGES)) u_port2 (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (strobe_q),
    .i_shift   (rd2_s),
    .i_buttons (i_buttons_2),
    .o_shift   (shift_2_s),
    .o_count   (o_debug_count_2)
  );

endmodule
